// File: rtl/inst_fetch_unit_if.sv
// Bundled instruction-SRAM request/response bus and fetch-buffer push port
// of the fetch unit. "master" is the fetch unit, "slave" is the environment.
interface inst_fetch_unit_if;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [63:0] bus_o;
  logic        excp_o;
  logic [3:0]  excp_num_o;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output inst_sram_req, inst_sram_addr, bus_o, excp_o, excp_num_o, out_valid,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, out_ready
  );

  modport slave (
    input  inst_sram_req, inst_sram_addr, bus_o, excp_o, excp_num_o, out_valid,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata, out_ready
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Sequential-PC fetch producer: issues split-handshake SRAM requests, pairs
// responses with their PCs and hands {pc, inst} bundles to the fetch buffer.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h1c00_0000,
  parameter logic [3:0]  ADEF_CODE = 4'h1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [31:0]       redirect_pc,
  input  logic              excp_flush,
  input  logic [31:0]       excp_entry,
  input  logic              ertn_flush,
  input  logic [31:0]       era,
  inst_fetch_unit_if.master fif
);

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
    logic [3:0]  num;
  } entry_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ifq [2];
  entry_t      skid [2];
  logic [1:0]  pend_cnt;
  logic [1:0]  disc_cnt;
  logic [1:0]  skid_cnt;

  logic        any_flush;
  logic [31:0] target;
  logic        credit;
  logic        can_issue;
  logic        req;
  logic        hs;
  logic        adef;
  logic        drop;
  logic        accept;
  logic        out_valid;
  logic        pop;
  logic        push;
  logic        ifq_wr;
  logic        skid_wr;
  entry_t      push_entry;

  // NOTE: every always_comb output gets a default up front so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    any_flush  = flush | excp_flush | ertn_flush;
    target     = excp_flush ? excp_entry : (ertn_flush ? era : redirect_pc);
    credit     = ({1'b0, pend_cnt} + {1'b0, skid_cnt}) < 3'd2;
    can_issue  = ~reset & (state == RUN) & credit & (disc_cnt == 2'd0) & ~any_flush;
    req        = can_issue & (pc[1:0] == 2'b00);
    adef       = can_issue & (pc[1:0] != 2'b00);
    hs         = req & fif.inst_sram_addr_ok;
    drop       = fif.inst_sram_data_ok & (disc_cnt != 2'd0);
    // A beat with nothing pending is a protocol error and falls through here.
    accept     = fif.inst_sram_data_ok & (disc_cnt == 2'd0) & (pend_cnt != 2'd0);
    out_valid  = ~reset & (skid_cnt != 2'd0);
    pop        = out_valid & fif.out_ready;
    // A misaligned PC only exists right after a redirect, when nothing is
    // pending, so accept and adef never coincide.
    push       = accept | adef;
    ifq_wr     = pend_cnt[0] & ~accept;
    skid_wr    = skid_cnt[0] & ~pop;
    push_entry = adef ? '{pc: pc, inst: 32'h0, excp: 1'b1, num: ADEF_CODE}
                      : '{pc: ifq[0], inst: fif.inst_sram_rdata, excp: 1'b0, num: 4'h0};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      pend_cnt <= 2'd0;
      disc_cnt <= 2'd0;
      skid_cnt <= 2'd0;
      state    <= RUN;
    end else if (any_flush) begin
      pc       <= target;
      pend_cnt <= 2'd0;
      // Everything still owed by the bus becomes a beat to throw away.
      disc_cnt <= disc_cnt - 2'(drop) + pend_cnt + 2'(hs) - 2'(accept);
      skid_cnt <= 2'd0;
      state    <= RUN;
    end else begin
      if (hs) pc <= pc + 32'd4;
      pend_cnt <= pend_cnt + 2'(hs) - 2'(accept);
      disc_cnt <= disc_cnt - 2'(drop);
      skid_cnt <= skid_cnt + 2'(push) - 2'(pop);
      if (adef) state <= HALT;
    end
  end

  // NOTE: queue payloads carry no reset; the occupancy counters above are
  // the only record of which slots hold live data.
  always_ff @(posedge clk) begin
    if (accept) ifq[0] <= ifq[1];
    if (hs)     ifq[ifq_wr] <= pc;
    if (pop)    skid[0] <= skid[1];
    if (push)   skid[skid_wr] <= push_entry;
  end

  assign fif.inst_sram_req  = req;
  assign fif.inst_sram_addr = pc;
  assign fif.out_valid      = out_valid;
  assign fif.bus_o          = {skid[0].pc, skid[0].inst};
  assign fif.excp_o         = out_valid & skid[0].excp;
  assign fif.excp_num_o     = (out_valid & skid[0].excp) ? skid[0].num : 4'h0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Random and directed bench for inst_fetch_unit: a program-order model
// predicts the bundle stream, a bus slave answers requests in order.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h1c00_0000;
  localparam logic [3:0]  ADEF_CODE = 4'h1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
    logic [3:0]  num;
  } bundle_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        excp_flush;
  logic [31:0] excp_entry;
  logic        ertn_flush;
  logic [31:0] era;

  inst_fetch_unit_if fif ();

  inst_fetch_unit #(.RESET_PC(RESET_PC), .ADEF_CODE(ADEF_CODE)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .excp_flush  (excp_flush),
    .excp_entry  (excp_entry),
    .ertn_flush  (ertn_flush),
    .era         (era),
    .fif         (fif)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_errors  = 0;
  int n_bundles = 0;
  int ok_pct    = 100;
  int data_pct  = 100;
  bit stale_beat = 1'b0;

  // Program-order model: after a redirect to T the stream is T, T+4, ...
  // unless T is misaligned, in which case it is one ADEF bundle and then nothing.
  bundle_t     exp_q [$];
  logic [31:0] gen_pc   = RESET_PC;
  bit          gen_halt = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h5a5a_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic refill();
    while (!gen_halt && exp_q.size() < 4) begin
      if (gen_pc[1:0] != 2'b00) begin
        exp_q.push_back('{pc: gen_pc, inst: 32'h0, excp: 1'b1, num: ADEF_CODE});
        gen_halt = 1'b1;
      end else begin
        exp_q.push_back('{pc: gen_pc, inst: mem_word(gen_pc), excp: 1'b0, num: 4'h0});
        gen_pc = gen_pc + 32'd4;
      end
    end
  endtask

  task automatic model_restart(input logic [31:0] t);
    exp_q.delete();
    gen_pc   = t;
    gen_halt = 1'b0;
    refill();
  endtask

  // Advance one cycle: apply the redirect seen at the edge, stop at the next negedge.
  task automatic step();
    @(posedge clk);
    if (reset)           model_restart(RESET_PC);
    else if (excp_flush) model_restart(excp_entry);
    else if (ertn_flush) model_restart(era);
    else if (flush)      model_restart(redirect_pc);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic redirect(input logic f, input logic e, input logic r,
                          input logic [31:0] rp, input logic [31:0] ee, input logic [31:0] ea);
    flush = f; excp_flush = e; ertn_flush = r;
    redirect_pc = rp; excp_entry = ee; era = ea;
    step();
    flush = 1'b0; excp_flush = 1'b0; ertn_flush = 1'b0;
  endtask

  // Bus slave: random addr_ok, in-order responses at least one cycle after acceptance.
  logic [31:0] mem_q [$];
  initial begin
    logic        hs;
    logic [31:0] a;
    bit          stale_now;
    fif.inst_sram_addr_ok = 1'b0;
    fif.inst_sram_data_ok = 1'b0;
    fif.inst_sram_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      stale_now = 1'b0;
      if (reset) begin
        fif.inst_sram_addr_ok = 1'($urandom_range(0, 1));
        fif.inst_sram_data_ok = 1'b0;
      end else if (stale_beat) begin
        stale_beat = 1'b0;
        stale_now  = 1'b1;
        fif.inst_sram_addr_ok = 1'b0;
        fif.inst_sram_data_ok = 1'b1;
        fif.inst_sram_rdata   = 32'hdead_beef;
      end else begin
        fif.inst_sram_addr_ok = ($urandom_range(0, 99) < ok_pct);
        if (mem_q.size() != 0 && $urandom_range(0, 99) < data_pct) begin
          fif.inst_sram_data_ok = 1'b1;
          fif.inst_sram_rdata   = mem_word(mem_q[0]);
        end else begin
          fif.inst_sram_data_ok = 1'b0;
          fif.inst_sram_rdata   = $urandom;
        end
      end
      #1;
      hs = fif.inst_sram_req & fif.inst_sram_addr_ok;
      a  = fif.inst_sram_addr;
      @(posedge clk);
      if (reset) mem_q.delete();
      else begin
        if (fif.inst_sram_data_ok && !stale_now) void'(mem_q.pop_front());
        if (hs) mem_q.push_back(a);
      end
    end
  end

  // Monitor: per-cycle protocol checks and scoreboard comparison on every handshake.
  initial begin
    bundle_t e;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        check("reset_req",      32'(fif.inst_sram_req), 32'h0);
        check("reset_valid",    32'(fif.out_valid),     32'h0);
        check("reset_excp",     32'(fif.excp_o),        32'h0);
        check("reset_excp_num", 32'(fif.excp_num_o),    32'h0);
      end else begin
        if (flush || excp_flush || ertn_flush)
          check("flush_cycle_req", 32'(fif.inst_sram_req), 32'h0);
        if (fif.inst_sram_req)
          check("req_aligned", 32'(fif.inst_sram_addr[1:0]), 32'h0);
        if (fif.out_valid && fif.out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_bundle: got pc %h inst %h, expected no bundle",
                     fif.bus_o[63:32], fif.bus_o[31:0]);
          end else begin
            e = exp_q.pop_front();
            check("bundle_pc",   fif.bus_o[63:32],       e.pc);
            check("bundle_inst", fif.bus_o[31:0],        e.inst);
            check("bundle_excp", 32'(fif.excp_o),        32'(e.excp));
            check("bundle_num",  32'(fif.excp_num_o),    32'(e.num));
            n_bundles++;
            refill();
          end
        end
      end
    end
  end

  initial begin
    int r;
    int n0;
    reset = 1'b1;
    flush = 1'b0; excp_flush = 1'b0; ertn_flush = 1'b0;
    redirect_pc = 32'h0; excp_entry = 32'h0; era = 32'h0;
    fif.out_ready = 1'b1;
    @(negedge clk);
    run(2);

    // Release reset with a stray response in the first cycle.
    stale_beat = 1'b1;
    reset = 1'b0;
    #3;
    check("first_req",  32'(fif.inst_sram_req), 32'h1);
    check("first_addr", fif.inst_sram_addr,      RESET_PC);
    step();
    run(30);

    // Back-pressure: the skid fills, requests stop.
    fif.out_ready = 1'b0;
    run(10);
    #3;
    check("stall_req",   32'(fif.inst_sram_req), 32'h0);
    check("stall_valid", 32'(fif.out_valid),     32'h1);
    step();
    fif.out_ready = 1'b1;
    run(10);

    // Redirect with two requests in flight.
    data_pct = 0;
    run(4);
    #3;
    check("pend2_req", 32'(fif.inst_sram_req), 32'h0);
    step();
    redirect(1'b1, 1'b0, 1'b0, 32'h1c00_0100, 32'h0, 32'h0);
    data_pct = 100;
    run(15);

    // Exception entry wins over a simultaneous redirect.
    redirect(1'b1, 1'b1, 1'b0, 32'h1c00_0200, 32'h1c00_8000, 32'h0);
    run(15);

    // Misaligned target: one ADEF bundle, then HALT until ERTN.
    redirect(1'b1, 1'b0, 1'b0, 32'h1c00_0102, 32'h0, 32'h0);
    run(10);
    #3;
    check("halt_req",       32'(fif.inst_sram_req), 32'h0);
    check("adef_delivered", 32'(exp_q.size()),      32'h0);
    step();
    redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1c00_0040);
    run(20);

    // Reset with requests outstanding.
    data_pct = 0;
    run(3);
    reset = 1'b1;
    run(2);
    stale_beat = 1'b1;
    reset = 1'b0;
    data_pct = 100;
    #3;
    check("rst2_req",  32'(fif.inst_sram_req), 32'h1);
    check("rst2_addr", fif.inst_sram_addr,      RESET_PC);
    step();
    run(20);

    // Random traffic with random redirects of all three kinds.
    ok_pct = 70;
    data_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      fif.out_ready = ($urandom_range(0, 99) < 80);
      r = int'($urandom_range(0, 999));
      if (r < 15)
        redirect(1'b1, 1'b0, 1'b0, {16'h1c00, 14'($urandom), 2'b00}, 32'h0, 32'h0);
      else if (r < 20)
        redirect(1'b1, 1'b0, 1'b0, {16'h1c00, 14'($urandom), 2'($urandom_range(1, 3))}, 32'h0, 32'h0);
      else if (r < 28)
        redirect(1'b0, 1'b1, 1'b0, 32'h0, {16'h1c00, 14'($urandom), 2'b00}, 32'h0);
      else if (r < 34)
        redirect(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, {16'h1c00, 14'($urandom), 2'b00});
      else if (r < 38)
        redirect(1'($urandom), 1'($urandom), 1'b1,
                 {16'h1c00, 14'($urandom), 2'b00},
                 {16'h1c00, 14'($urandom), 2'b00},
                 {16'h1c00, 14'($urandom), 2'b00});
      else
        step();
    end

    // Drain from a known-good target and confirm forward progress.
    ok_pct = 100;
    data_pct = 100;
    fif.out_ready = 1'b1;
    redirect(1'b1, 1'b0, 1'b0, 32'h1c00_1000, 32'h0, 32'h0);
    n0 = n_bundles;
    run(40);
    check("drain_progress", 32'(n_bundles - n0 >= 5), 32'h1);
    check("total_bundles",  32'(n_bundles > 200),     32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
